// File: rtl/bus_map_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_map_pkg
// Description : Data-memory bus address map, UART STATUS bit positions and
//               UART transmitter FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_map_pkg;

    // Peripheral addresses on the data-memory bus
    localparam logic [15:0] GPI_A      = 16'h100;
    localparam logic [15:0] GPO_A      = 16'h101;
    localparam logic [15:0] UART_TXD_A = 16'h102;
    localparam logic [15:0] UART_STA_A = 16'h103;

    // UART STATUS register bit positions
    localparam int STA_BUSY  = 0;
    localparam int STA_FULL  = 1;
    localparam int STA_EMPTY = 2;
    localparam int STA_OVF   = 3;

    // UART transmitter frame states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with first-word fall-through read port.
//               Push while full is accepted only when a pop happens in the
//               same cycle; pop while empty is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int              c_PW   = $clog2(DEPTH);
    localparam logic [c_PW:0]   c_FULL = DEPTH[c_PW:0];

    logic [W-1:0]  r_mem_q [DEPTH];
    logic [c_PW-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PW-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_PW:0]   r_count_q,  w_count_d;
    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_count_q == c_FULL);
    assign empty     = (r_count_q == '0);
    assign dout      = r_mem_q[r_rd_ptr_q];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Next pointer and occupancy; pointers wrap naturally at the power-of-2 depth
    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_do_push) w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        if (w_do_pop)  w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
    end

    // Pointer/occupancy registers; reset flushes the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem_q[r_wr_ptr_q] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_mmio
// Description : Memory-mapped 8N1 UART transmitter with TX FIFO. TXDATA at
//               BASE_A (write pushes a byte), STATUS at BASE_A+1
//               ({ovf, empty, full, busy}; writing bit 3 clears ovf).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_mmio
    import bus_map_pkg::*;
#(
    parameter int            DW         = 16,
    parameter int            AW         = 16,
    parameter int            CLK_DIV    = 868,
    parameter int            FIFO_DEPTH = 4,
    parameter logic [AW-1:0] BASE_A     = AW'(UART_TXD_A)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    input  logic          we,
    output logic [DW-1:0] dout,
    output logic          sel,
    output logic          tx
);

    localparam int              c_CW      = $clog2(CLK_DIV);
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(CLK_DIV - 1);
    localparam logic [AW-1:0]   c_STA_A   = BASE_A + AW'(1);

    tx_state_e       r_state_q, w_state_d;
    logic [c_CW-1:0] r_cnt_q,   w_cnt_d;
    logic [2:0]      r_bit_q,   w_bit_d;
    logic [7:0]      r_shift_q, w_shift_d;
    logic            r_tx_q,    w_tx_d;
    logic            r_ovf_q,   w_ovf_d;
    logic [AW-1:0]   r_addr_q,  w_addr_d;

    logic            w_wr_data;
    logic            w_wr_sta;
    logic            w_pop;
    logic            w_overflow;
    logic            w_cnt_end;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [7:0]      w_fifo_dout;
    logic [DW-1:0]   w_status;

    assign w_wr_data  = we && (addr == BASE_A);
    assign w_wr_sta   = we && (addr == c_STA_A);
    assign w_overflow = w_wr_data && w_fifo_full && !w_pop;
    assign w_cnt_end  = (r_cnt_q == c_CNT_MAX);

    sync_fifo #(
        .W     (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_wr_data),
        .pop   (w_pop),
        .din   (din[7:0]),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // Upper write-data bits carry nothing for this block
    if (DW > 8) begin : g_unused_din
        logic w_unused_hi;
        assign w_unused_hi = ^din[DW-1:8];
    end

    // Frame sequencer: tx_d is the line level for the bit period starting next edge
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_bit_d   = r_bit_q;
        w_shift_d = r_shift_q;
        w_tx_d    = r_tx_q;
        w_pop     = 1'b0;
        case (r_state_q)
            IDLE: begin
                w_tx_d  = 1'b1;
                w_cnt_d = '0;
                if (!w_fifo_empty) begin
                    w_pop     = 1'b1;
                    w_shift_d = w_fifo_dout;
                    w_state_d = START;
                    w_tx_d    = 1'b0;
                end
            end
            START: begin
                if (w_cnt_end) begin
                    w_cnt_d   = '0;
                    w_bit_d   = 3'd0;
                    w_state_d = DATA;
                    w_tx_d    = r_shift_q[0];
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (w_cnt_end) begin
                    w_cnt_d = '0;
                    if (r_bit_q == 3'd7) begin
                        w_state_d = STOP;
                        w_tx_d    = 1'b1;
                    end else begin
                        w_bit_d   = r_bit_q + 1'b1;
                        w_shift_d = {1'b0, r_shift_q[7:1]};
                        w_tx_d    = r_shift_q[1];
                    end
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (w_cnt_end) begin
                    w_cnt_d = '0;
                    if (!w_fifo_empty) begin
                        // Chain the next queued byte with no idle gap
                        w_pop     = 1'b1;
                        w_shift_d = w_fifo_dout;
                        w_state_d = START;
                        w_tx_d    = 1'b0;
                    end else begin
                        w_state_d = IDLE;
                        w_tx_d    = 1'b1;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_cnt_d   = '0;
                w_tx_d    = 1'b1;
            end
        endcase
    end

    // Sticky overflow and bus address latch; a new overflow beats a clear
    always_comb begin
        w_ovf_d = r_ovf_q;
        if (w_wr_sta && din[STA_OVF]) w_ovf_d = 1'b0;
        if (w_overflow)               w_ovf_d = 1'b1;
        w_addr_d = we ? r_addr_q : addr;
    end

    // All control state; reset abandons any frame in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_cnt_q   <= '0;
            r_bit_q   <= '0;
            r_shift_q <= '0;
            r_tx_q    <= 1'b1;
            r_ovf_q   <= 1'b0;
            r_addr_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_bit_q   <= w_bit_d;
            r_shift_q <= w_shift_d;
            r_tx_q    <= w_tx_d;
            r_ovf_q   <= w_ovf_d;
            r_addr_q  <= w_addr_d;
        end
    end

    // Read mux: STATUS word assembled from live state, TXDATA reads as zero
    always_comb begin
        w_status            = '0;
        w_status[STA_BUSY]  = (r_state_q != IDLE) | ~w_fifo_empty;
        w_status[STA_FULL]  = w_fifo_full;
        w_status[STA_EMPTY] = w_fifo_empty;
        w_status[STA_OVF]   = r_ovf_q;
    end

    assign sel  = (r_addr_q == BASE_A) || (r_addr_q == c_STA_A);
    assign dout = (r_addr_q == c_STA_A) ? w_status : '0;
    assign tx   = r_tx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_mmio
// Description : Self-checking bench for uart_tx_mmio (CLK_DIV=4, depth 4)
//               against a frame-position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_mmio;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int FRAME   = 10 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        sel;
    logic        tx;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .DW         (16),
        .AW         (16),
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH),
        .BASE_A     (16'h102)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .din  (din),
        .we   (we),
        .dout (dout),
        .sel  (sel),
        .tx   (tx)
    );

    // Reference model: a byte queue plus the cycle position inside the current frame
    int          m_pos    = -1;
    logic [7:0]  m_cur    = 8'h00;
    logic [7:0]  m_q[$];
    bit          m_ovf    = 1'b0;
    logic [15:0] m_addr_r = 16'h0000;

    function automatic logic m_tx();
        int idx;
        if (m_pos < 0) return 1'b1;
        idx = m_pos / CLK_DIV;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_cur[idx-1];
    endfunction

    function automatic logic [15:0] m_status();
        logic [15:0] s;
        s    = 16'h0000;
        s[3] = m_ovf;
        s[2] = (m_q.size() == 0);
        s[1] = (m_q.size() == DEPTH);
        s[0] = (m_pos >= 0) || (m_q.size() != 0);
        return s;
    endfunction

    function automatic logic m_sel();
        return (m_addr_r == 16'h102) || (m_addr_r == 16'h103);
    endfunction

    function automatic logic [15:0] m_dout();
        return (m_addr_r == 16'h103) ? m_status() : 16'h0000;
    endfunction

    function automatic bit m_idle();
        return (m_pos < 0) && (m_q.size() == 0);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pos    = -1;
            m_q.delete();
            m_ovf    = 1'b0;
            m_addr_r = 16'h0000;
        end else begin
            if (m_pos < 0 || m_pos == FRAME - 1) begin
                if (m_q.size() > 0) begin
                    m_cur = m_q.pop_front();
                    m_pos = 0;
                end else begin
                    m_pos = -1;
                end
            end else begin
                m_pos++;
            end
            if (we && addr == 16'h103 && din[3]) m_ovf = 1'b0;
            if (we && addr == 16'h102) begin
                if (m_q.size() < DEPTH) m_q.push_back(din[7:0]);
                else                    m_ovf = 1'b1;
            end
            if (!we) m_addr_r = addr;
        end
    end

    task automatic bus(input logic w, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        we   = w;
        addr = a;
        din  = d;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            we = 1'b0;
            n_total++;
            if (tx !== m_tx() || sel !== m_sel() || dout !== m_dout()) begin
                n_bad++;
                $display("FAIL idle_wait_track: tx=%b sel=%b dout=%h want tx=%b sel=%b dout=%h",
                         tx, sel, dout, m_tx(), m_sel(), m_dout());
            end
            if (m_idle()) done = 1'b1;
        end
        if (!done) begin
            n_total++;
            n_bad++;
            $display("FAIL idle_timeout: got busy want idle");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; addr = 16'h103; din = 16'h0000;
        repeat (2) begin
            @(negedge clk);
            n_total++;
            if (tx !== 1'b1 || sel !== 1'b0 || dout !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_state: tx=%b sel=%b dout=%h want 1 0 0000", tx, sel, dout);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (sel !== 1'b1 || dout !== 16'h0004 || tx !== 1'b1) begin
            n_bad++;
            $display("FAIL status_after_reset: sel=%b dout=%h tx=%b want 1 0004 1", sel, dout, tx);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        logic       exp;
        b = 8'h55;
        bus(1'b1, 16'h102, 16'h0055);
        bus(1'b0, 16'h103, 16'h0000);
        for (int k = 0; k <= FRAME + 4; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 1)        exp = 1'b1;
            else if (k <= 4)  exp = 1'b0;
            else if (k <= 36) exp = b[(k-5)/4];
            else              exp = 1'b1;
            n_total++;
            if (tx !== exp || tx !== m_tx()) begin
                n_bad++;
                $display("FAIL frame55_tx k=%0d: got %b want %b", k, tx, exp);
            end
            if (k == 40) begin
                n_total++;
                if (dout[0] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL busy_last_stop: got %b want 1", dout[0]);
                end
            end
            if (k == 41) begin
                n_total++;
                if (dout !== 16'h0004) begin
                    n_bad++;
                    $display("FAIL status_after_frame: got %h want 0004", dout);
                end
            end
        end
    endtask

    task automatic test_burst();
        int  first_idle;
        wait_idle();
        for (int i = 0; i < 6; i++) bus(1'b1, 16'h102, 16'($urandom_range(0, 65535)));
        bus(1'b0, 16'h103, 16'h0000);
        @(negedge clk);
        n_total++;
        if (dout !== 16'h000B) begin
            n_bad++;
            $display("FAIL burst_status: got %h want 000B", dout);
        end
        // Cycle 6 after the first write edge is checked above; busy must last through edge 200
        first_idle = -1;
        for (int c = 7; c <= 5 * FRAME + 10; c++) begin
            @(negedge clk);
            n_total++;
            if (tx !== m_tx() || dout !== m_dout()) begin
                n_bad++;
                $display("FAIL burst_track c=%0d: tx=%b dout=%h want tx=%b dout=%h",
                         c, tx, dout, m_tx(), m_dout());
            end
            if (first_idle < 0 && dout[0] === 1'b0) first_idle = c;
        end
        n_total++;
        if (first_idle != 5 * FRAME + 1) begin
            n_bad++;
            $display("FAIL burst_length: got idle at %0d want %0d", first_idle, 5 * FRAME + 1);
        end
    endtask

    task automatic test_ovf_clear();
        bus(1'b1, 16'h103, 16'h0000);
        @(negedge clk);
        n_total++;
        if (dout !== 16'h000C) begin
            n_bad++;
            $display("FAIL ovf_kept_on_zero_write: got %h want 000C", dout);
        end
        bus(1'b1, 16'h103, 16'h0008);
        bus(1'b0, 16'h103, 16'h0000);
        n_total++;
        if (dout !== 16'h0004) begin
            n_bad++;
            $display("FAIL ovf_cleared: got %h want 0004", dout);
        end
    endtask

    task automatic test_other_addr();
        logic [15:0] a [3];
        a[0] = 16'h100; a[1] = 16'h101; a[2] = 16'h104;
        for (int i = 0; i < 3; i++) begin
            bus(1'b0, a[i], 16'hFFFF);
            @(negedge clk);
            n_total++;
            if (sel !== 1'b0 || dout !== 16'h0000) begin
                n_bad++;
                $display("FAIL foreign_read %h: sel=%b dout=%h want 0 0000", a[i], sel, dout);
            end
        end
        bus(1'b1, 16'h101, 16'h0041);
        bus(1'b0, 16'h103, 16'h0000);
        for (int i = 0; i < FRAME + 5; i++) begin
            @(negedge clk);
            n_total++;
            if (tx !== 1'b1 || dout !== 16'h0004) begin
                n_bad++;
                $display("FAIL foreign_write i=%0d: tx=%b dout=%h want 1 0004", i, tx, dout);
            end
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 15);
            if (r < 2)       bus(1'b1, 16'h102, 16'($urandom_range(0, 65535)));
            else if (r == 2) bus(1'b1, 16'h103, 16'($urandom_range(0, 65535)));
            else if (r == 3) bus(1'b1, 16'h100 + 16'($urandom_range(0, 4)) * 16'(r != 3), 16'($urandom));
            else             bus(1'b0, 16'h100 + 16'($urandom_range(0, 4)), 16'($urandom));
            n_total++;
            if (tx !== m_tx() || sel !== m_sel() || dout !== m_dout()) begin
                n_bad++;
                $display("FAIL random i=%0d: tx=%b sel=%b dout=%h want tx=%b sel=%b dout=%h",
                         i, tx, sel, dout, m_tx(), m_sel(), m_dout());
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit hit;
        wait_idle();
        for (int i = 0; i < 3; i++) bus(1'b1, 16'h102, 16'($urandom_range(0, 255)));
        bus(1'b0, 16'h103, 16'h0000);
        hit = 1'b0;
        // DATA bit 3 occupies frame positions 16..19
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (m_pos == 4 * CLK_DIV + 1) hit = 1'b1;
        end
        n_total++;
        if (!hit) begin
            n_bad++;
            $display("FAIL reach_data_bit3: got no frame want frame position %0d", 4 * CLK_DIV + 1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++;
        if (tx !== 1'b1 || sel !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_frame: tx=%b sel=%b want 1 0", tx, sel);
        end
        @(negedge clk);
        n_total++;
        if (dout !== 16'h0004) begin
            n_bad++;
            $display("FAIL status_after_mid_reset: got %h want 0004", dout);
        end
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            n_total++;
            if (tx !== 1'b1) begin
                n_bad++;
                $display("FAIL no_frame_after_reset i=%0d: got %b want 1", i, tx);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_burst();
        test_ovf_clear();
        test_other_addr();
        test_random();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
